// File: rtl/stage_3_pkg.sv
// Shared encoder parameters for the stage_3 low/count update: widths, flush
// constants, FSM encoding and the low-bit mask helper.
package stage_3_pkg;

  localparam int RANGE_WIDTH_DEF = 16;
  localparam int D_SIZE_DEF      = 5;
  localparam int LOW_WIDTH_DEF   = 24;
  localparam int CNT_W           = 7;
  localparam int WORD_W          = 9;

  localparam logic signed [CNT_W-1:0] CNT_INIT = -7'sd9;
  localparam logic [31:0] FLUSH_MASK = 32'h0000_3FFF;
  localparam logic [31:0] FLUSH_TOP  = 32'h0000_4000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // 2^c - 1, saturating for out-of-range shift counts
  function automatic logic [31:0] low_mask(input logic signed [31:0] c);
    if (c <= 32'sd0) return 32'd0;
    if (c >= 32'sd32) return '1;
    return (32'd1 << c) - 32'd1;
  endfunction

endpackage

// File: rtl/stage_3_if.sv
// Handshake and data bundle between stage_2 and stage_3; master drives the
// symbol inputs, slave (stage_3) returns ready and the precarry words.
interface stage_3_if #(
  parameter int RANGE_WIDTH = 16,
  parameter int D_SIZE      = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   flush;
  logic [RANGE_WIDTH:0]   u;
  logic [RANGE_WIDTH-1:0] initial_range_1;
  logic [RANGE_WIDTH-1:0] pre_low_1;
  logic [RANGE_WIDTH-1:0] pre_low_2;
  logic [D_SIZE-1:0]      d_1;
  logic [D_SIZE-1:0]      d_2;
  logic                   bool_1;
  logic                   bool_2;
  logic                   symbol_1;
  logic                   symbol_2;
  logic                   COMP_mux_1;
  logic [8:0]             out_word_1;
  logic [8:0]             out_word_2;
  logic                   out_valid_1;
  logic                   out_valid_2;
  logic                   flush_done;

  modport master (
    output in_valid, flush, u, initial_range_1, pre_low_1, pre_low_2, d_1, d_2,
           bool_1, bool_2, symbol_1, symbol_2, COMP_mux_1,
    input  in_ready, out_word_1, out_word_2, out_valid_1, out_valid_2, flush_done
  );

  modport slave (
    input  in_valid, flush, u, initial_range_1, pre_low_1, pre_low_2, d_1, d_2,
           bool_1, bool_2, symbol_1, symbol_2, COMP_mux_1,
    output in_ready, out_word_1, out_word_2, out_valid_1, out_valid_2, flush_done
  );
endinterface

// File: rtl/stage_3_low_norm.sv
// s3_low_norm: optional add into low followed by one normalization step;
// emits up to two unresolved 9-bit precarry words (word_a is older).
module s3_low_norm
  import stage_3_pkg::*;
#(
  parameter int LOW_WIDTH = LOW_WIDTH_DEF,
  parameter int D_SIZE    = D_SIZE_DEF
) (
  input  logic                    en,
  input  logic                    add_en,
  input  logic [LOW_WIDTH-1:0]    add_val,
  input  logic [D_SIZE-1:0]       d,
  input  logic [LOW_WIDTH-1:0]    low_cur,
  input  logic signed [CNT_W-1:0] cnt_cur,
  output logic [LOW_WIDTH-1:0]    low_new,
  output logic signed [CNT_W-1:0] cnt_new,
  output logic [1:0]              n_words,
  output logic [WORD_W-1:0]       word_a,
  output logic [WORD_W-1:0]       word_b
);
  logic [LOW_WIDTH-1:0] low;
  logic [LOW_WIDTH-1:0] hi;
  logic signed [31:0]   s;
  logic signed [31:0]   c;
  logic signed [31:0]   d_ext;

  always_comb begin
    low     = low_cur;
    hi      = '0;
    s       = '0;
    c       = '0;
    d_ext   = 32'(d);
    low_new = low_cur;
    cnt_new = cnt_cur;
    n_words = 2'd0;
    word_a  = '0;
    word_b  = '0;
    if (en) begin
      if (add_en) low = low + add_val;
      s = 32'(cnt_cur) + d_ext;
      if (s >= 32'sd0) begin
        c = 32'(cnt_cur) + 32'sd16;
        if (s >= 32'sd8) begin
          hi      = low >> c;
          word_a  = hi[WORD_W-1:0];
          low     = low & LOW_WIDTH'(low_mask(c));
          c       = c - 32'sd8;
          n_words = 2'd1;
        end
        hi = low >> c;
        if (n_words == 2'd1) word_b = hi[WORD_W-1:0];
        else                 word_a = hi[WORD_W-1:0];
        low     = low & LOW_WIDTH'(low_mask(c));
        n_words = n_words + 2'd1;
        s       = c + d_ext - 32'sd24;
      end
      low_new = low << d;
      cnt_new = s[CNT_W-1:0];
    end
  end
endmodule

// File: rtl/stage_3.sv
// stage_3: range-coder low/count update with precarry word output and
// end-of-frame flush sequencing.
//   state    | meaning
//   ST_RUN   | accepting symbols; flush request starts end-of-frame
//   ST_FLUSH | draining the padded low one word per cycle
//   ST_DONE  | frame closed; idle until reset
module stage_3
  import stage_3_pkg::*;
#(
  parameter int RANGE_WIDTH = RANGE_WIDTH_DEF,
  parameter int D_SIZE      = D_SIZE_DEF,
  parameter int LOW_WIDTH   = LOW_WIDTH_DEF
) (
  input  logic     clk,
  input  logic     reset,
  stage_3_if.slave bus
);
  state_t state_q, state_nxt;
  logic [LOW_WIDTH-1:0]    low_q, low_nxt, fl_e_q, fl_e_nxt, fl_hi;
  logic signed [CNT_W-1:0] cnt_q, cnt_nxt, fl_c_q, fl_c_nxt, fl_s_q, fl_s_nxt;
  logic [WORD_W-1:0]       w1_q, w1_nxt, w2_q, w2_nxt;
  logic                    v1_q, v1_nxt, v2_q, v2_nxt, done_q, done_nxt;
  logic signed [31:0]      fl_sh;

  logic [LOW_WIDTH-1:0]    low_a, low_b, add_a;
  logic signed [CNT_W-1:0] cnt_a, cnt_b;
  logic [1:0]              na, nb;
  logic [WORD_W-1:0]       wa_a, wa_b, wb_a, wb_b;
  logic [2:0]              total;
  logic                    run, xfer;
  logic                    unused_u_top;

  assign unused_u_top = bus.u[RANGE_WIDTH];
  assign run   = (state_q == ST_RUN);
  assign xfer  = run & bus.in_valid;
  assign add_a = bus.bool_1 ? LOW_WIDTH'(bus.pre_low_1)
                            : LOW_WIDTH'(bus.initial_range_1) - LOW_WIDTH'(bus.u[RANGE_WIDTH-1:0]);

  s3_low_norm #(.LOW_WIDTH(LOW_WIDTH), .D_SIZE(D_SIZE)) u_norm_1 (
    .en(1'b1), .add_en(bus.bool_1 ? bus.symbol_1 : bus.COMP_mux_1), .add_val(add_a),
    .d(bus.d_1), .low_cur(low_q), .cnt_cur(cnt_q), .low_new(low_a), .cnt_new(cnt_a),
    .n_words(na), .word_a(wa_a), .word_b(wa_b)
  );

  s3_low_norm #(.LOW_WIDTH(LOW_WIDTH), .D_SIZE(D_SIZE)) u_norm_2 (
    .en(bus.bool_1 & bus.bool_2), .add_en(bus.symbol_2), .add_val(LOW_WIDTH'(bus.pre_low_2)),
    .d(bus.d_2), .low_cur(low_a), .cnt_cur(cnt_a), .low_new(low_b), .cnt_new(cnt_b),
    .n_words(nb), .word_a(wb_a), .word_b(wb_b)
  );

  assign total = {1'b0, na} + {1'b0, nb};

  always_comb begin
    state_nxt = state_q;
    low_nxt   = low_q;
    cnt_nxt   = cnt_q;
    fl_e_nxt  = fl_e_q;
    fl_c_nxt  = fl_c_q;
    fl_s_nxt  = fl_s_q;
    w1_nxt    = '0;
    w2_nxt    = '0;
    v1_nxt    = 1'b0;
    v2_nxt    = 1'b0;
    done_nxt  = 1'b0;
    fl_sh     = 32'(fl_c_q) + 32'sd16;
    fl_hi     = fl_e_q >> fl_sh;
    case (state_q)
      ST_RUN: begin
        if (xfer) begin
          low_nxt = low_b;
          cnt_nxt = cnt_b;
          v1_nxt  = (total >= 3'd1);
          v2_nxt  = (total >= 3'd2);
          w1_nxt  = (na != 2'd0) ? wa_a : wb_a;
          w2_nxt  = (na == 2'd2) ? wa_b : ((na == 2'd1) ? wb_a : wb_b);
        end else if (bus.flush) begin
          // round low up to the 2^14 grid and set the stop bit above it
          fl_e_nxt  = ((low_q + LOW_WIDTH'(FLUSH_MASK)) & ~LOW_WIDTH'(FLUSH_MASK))
                      | LOW_WIDTH'(FLUSH_TOP);
          fl_c_nxt  = cnt_q;
          fl_s_nxt  = cnt_q + 7'sd10;
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fl_s_q > 7'sd0) begin
          w1_nxt   = fl_hi[WORD_W-1:0];
          v1_nxt   = 1'b1;
          fl_e_nxt = fl_e_q & LOW_WIDTH'(low_mask(fl_sh));
          fl_c_nxt = fl_c_q - 7'sd8;
          fl_s_nxt = fl_s_q - 7'sd8;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      low_q   <= '0;
      cnt_q   <= CNT_INIT;
      fl_e_q  <= '0;
      fl_c_q  <= '0;
      fl_s_q  <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      low_q   <= low_nxt;
      cnt_q   <= cnt_nxt;
      fl_e_q  <= fl_e_nxt;
      fl_c_q  <= fl_c_nxt;
      fl_s_q  <= fl_s_nxt;
      w1_q    <= w1_nxt;
      w2_q    <= w2_nxt;
      v1_q    <= v1_nxt;
      v2_q    <= v2_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.in_ready    = run;
  assign bus.out_word_1  = w1_q;
  assign bus.out_word_2  = w2_q;
  assign bus.out_valid_1 = v1_q;
  assign bus.out_valid_2 = v2_q;
  assign bus.flush_done  = done_q;
endmodule

// File: tb/tb_stage_3.sv
// Bench for stage_3: directed reset/transfer/flush cases, then random frames
// checked against an arithmetic model of the low/cnt update and flush.
module tb_stage_3;
  import stage_3_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stage_3_if #(.RANGE_WIDTH(16), .D_SIZE(5)) bus ();
  stage_3 #(.RANGE_WIDTH(16), .D_SIZE(5), .LOW_WIDTH(24)) dut (.clk(clk), .reset(reset), .bus(bus));

  localparam longint M24 = 64'hFF_FFFF;
  int n_checks = 0;
  int n_errors = 0;
  longint m_low;
  int     m_cnt;
  int     m_words[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic void m_norm(input int d);
    int s, c;
    s = m_cnt + d;
    if (s >= 0) begin
      c = m_cnt + 16;
      if (s >= 8) begin
        m_words.push_back(int'((m_low >> c) & 511));
        m_low &= (64'd1 << c) - 1;
        c -= 8;
      end
      m_words.push_back(int'((m_low >> c) & 511));
      m_low &= (64'd1 << c) - 1;
      s = c + d - 24;
    end
    m_low = (m_low << d) & M24;
    m_cnt = s;
  endfunction

  function automatic void m_apply(input bit b1, b2, s1, s2, cm, input int ir, uu, p1, p2, d1, d2);
    m_words.delete();
    if (!b1) begin
      if (cm) m_low = (m_low + ir - uu) & M24;
      m_norm(d1);
    end else begin
      if (s1) m_low = (m_low + p1) & M24;
      m_norm(d1);
      if (b2) begin
        if (s2) m_low = (m_low + p2) & M24;
        m_norm(d2);
      end
    end
  endfunction

  function automatic void m_flush();
    longint e;
    int fc, fs;
    m_words.delete();
    e  = (((m_low + 64'h3FFF) & ~64'h3FFF) | 64'h4000) & M24;
    fc = m_cnt;
    fs = m_cnt + 10;
    while (fs > 0) begin
      m_words.push_back(int'((e >> (fc + 16)) & 511));
      e &= (64'd1 << (fc + 16)) - 1;
      fc -= 8;
      fs -= 8;
    end
  endfunction

  task automatic idle();
    bus.in_valid = 0; bus.flush = 0; bus.u = '0; bus.initial_range_1 = '0;
    bus.pre_low_1 = '0; bus.pre_low_2 = '0; bus.d_1 = '0; bus.d_2 = '0;
    bus.bool_1 = 0; bus.bool_2 = 0; bus.symbol_1 = 0; bus.symbol_2 = 0; bus.COMP_mux_1 = 0;
  endtask

  task automatic drive(input bit b1, b2, s1, s2, cm, input int ir, uu, p1, p2, d1, d2);
    bus.in_valid = 1; bus.bool_1 = b1; bus.bool_2 = b2; bus.symbol_1 = s1; bus.symbol_2 = s2;
    bus.COMP_mux_1 = cm; bus.initial_range_1 = 16'(ir);
    bus.u = {1'($urandom_range(0, 1)), 16'(uu)};
    bus.pre_low_1 = 16'(p1); bus.pre_low_2 = 16'(p2); bus.d_1 = 5'(d1); bus.d_2 = 5'(d2);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; idle();
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 0;
    m_low = 0; m_cnt = -9; m_words.delete();
  endtask

  task automatic check_xfer(input string tag);
    check({tag, "_v1"}, bus.out_valid_1, m_words.size() >= 1);
    check({tag, "_v2"}, bus.out_valid_2, m_words.size() >= 2);
    if (m_words.size() >= 1) check({tag, "_w1"}, bus.out_word_1, m_words[0]);
    if (m_words.size() >= 2) check({tag, "_w2"}, bus.out_word_2, m_words[1]);
    check({tag, "_low"}, dut.low_q, m_low);
    check({tag, "_cnt"}, dut.cnt_q, m_cnt);
  endtask

  task automatic run_flush(input string tag);
    m_flush();
    bus.flush = 1; step(); bus.flush = 0;
    check({tag, "_entry_rdy"}, bus.in_ready, 0);
    check({tag, "_entry_v1"}, bus.out_valid_1, 0);
    foreach (m_words[k]) begin
      step();
      check({tag, "_fv1"}, bus.out_valid_1, 1);
      check({tag, "_fw1"}, bus.out_word_1, m_words[k]);
      check({tag, "_fdone0"}, bus.flush_done, 0);
    end
    step();
    check({tag, "_done"}, bus.flush_done, 1);
    check({tag, "_done_v1"}, bus.out_valid_1, 0);
    step();
    check({tag, "_done_pulse"}, bus.flush_done, 0);
    check({tag, "_done_rdy"}, bus.in_ready, 0);
  endtask

  initial begin
    bit b1, b2, s1, s2, cm, ok;
    int ir, uu, p1, p2, d1, d2;
    longint sv_low;
    int sv_cnt;

    reset = 1; idle();
    do_reset();
    check("rst_rdy", bus.in_ready, 1);
    check("rst_v1", bus.out_valid_1, 0);
    check("rst_v2", bus.out_valid_2, 0);
    check("rst_done", bus.flush_done, 0);
    check("rst_w1", bus.out_word_1, 0);
    check("rst_low", dut.low_q, 0);
    check("rst_cnt", dut.cnt_q, -9);

    // single bool symbol, no low increment
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    m_apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(); idle();
    check("bool_cnt", dut.cnt_q, -8);
    check("bool_low", dut.low_q, 0);
    check_xfer("bool");

    do_reset();
    drive(0, 0, 0, 0, 1, 32768, 20000, 0, 0, 15, 0);
    step(); idle();
    check("cdf_v1", bus.out_valid_1, 1);
    check("cdf_v2", bus.out_valid_2, 0);
    check("cdf_w1", bus.out_word_1, 99);
    check("cdf_low", dut.low_q, 3145728);
    check("cdf_cnt", dut.cnt_q, -2);

    // flush from reset; symbols offered during the flush must be ignored
    do_reset();
    bus.flush = 1; step(); bus.flush = 0;
    check("fl0_rdy", bus.in_ready, 0);
    check("fl0_v1", bus.out_valid_1, 0);
    drive(0, 0, 0, 0, 1, 32768, 20000, 0, 0, 15, 0);
    step();
    check("fl0_v1b", bus.out_valid_1, 1);
    check("fl0_w1", bus.out_word_1, 128);
    check("fl0_done0", bus.flush_done, 0);
    step();
    check("fl0_done", bus.flush_done, 1);
    check("fl0_done_v1", bus.out_valid_1, 0);
    step();
    check("fl0_pulse", bus.flush_done, 0);
    check("fl0_rdy_done", bus.in_ready, 0);
    check("fl0_v1_done", bus.out_valid_1, 0);
    check("fl0_low_kept", dut.low_q, 0);
    idle();

    // transfer wins over a simultaneous flush
    do_reset();
    drive(0, 0, 0, 0, 1, 32768, 20000, 0, 0, 15, 0);
    bus.flush = 1;
    step(); idle();
    check("both_w1", bus.out_word_1, 99);
    check("both_v1", bus.out_valid_1, 1);
    check("both_rdy", bus.in_ready, 1);
    step();
    check("both_idle_v1", bus.out_valid_1, 0);
    check("both_idle_rdy", bus.in_ready, 1);

    // reset during the first flush cycle aborts it
    do_reset();
    bus.flush = 1; step(); bus.flush = 0;
    reset = 1; step(); reset = 0;
    check("abort_v1", bus.out_valid_1, 0);
    check("abort_done", bus.flush_done, 0);
    check("abort_cnt", dut.cnt_q, -9);
    check("abort_rdy", bus.in_ready, 1);
    step();
    check("abort_done2", bus.flush_done, 0);
    check("abort_v1_2", bus.out_valid_1, 0);

    // random frames
    for (int f = 0; f < 4; f++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          idle(); m_words.delete();
          step();
          check("rnd_idle_v1", bus.out_valid_1, 0);
          check("rnd_idle_v2", bus.out_valid_2, 0);
        end else begin
          ok = 0;
          for (int t = 0; t < 20 && !ok; t++) begin
            b1 = 1'($urandom_range(0, 1)); b2 = 1'($urandom_range(0, 1));
            s1 = 1'($urandom_range(0, 1)); s2 = 1'($urandom_range(0, 1));
            cm = 1'($urandom_range(0, 1));
            ir = int'($urandom_range(256, 65535)); uu = int'($urandom_range(0, ir));
            p1 = int'($urandom_range(0, 65535)); p2 = int'($urandom_range(0, 65535));
            d1 = b1 ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
            d2 = int'($urandom_range(0, 3));
            sv_low = m_low; sv_cnt = m_cnt;
            m_apply(b1, b2, s1, s2, cm, ir, uu, p1, p2, d1, d2);
            if (m_words.size() <= 2) ok = 1;
            else begin m_low = sv_low; m_cnt = sv_cnt; m_words.delete(); end
          end
          if (ok) begin
            drive(b1, b2, s1, s2, cm, ir, uu, p1, p2, d1, d2);
            step(); idle();
            check_xfer("rnd");
          end
        end
      end
      run_flush("rnd_flush");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/stage_3.md
STAGE_3 -- requirements
Module: stage_3

Interface
REQ-001 Parameter RANGE_WIDTH, default 16, range/u datapath width.
REQ-002 Parameter D_SIZE, default 5, normalization shift width.
REQ-003 Parameter LOW_WIDTH, default 24, low register width.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  stage_2 outputs present this cycle.
REQ-007 Port in_ready  output  1  stage accepts input; transfer = in_valid & in_ready.
REQ-008 Port flush  input  1  end-of-frame request; sampled only when no input transfer occurs.
REQ-009 Port u  input  RANGE_WIDTH+1  CDF u value from stage_2.
REQ-010 Port initial_range_1  input  RANGE_WIDTH  range entering this symbol.
REQ-011 Port pre_low_1, pre_low_2  input  RANGE_WIDTH each  boolean low increments.
REQ-012 Port d_1, d_2  input  D_SIZE each  normalization shifts.
REQ-013 Port bool_1, bool_2, symbol_1, symbol_2, COMP_mux_1  input  1 each  mode/symbol flags.
REQ-014 Port out_word_1, out_word_2  output  9 each  precarry bytes (bit 8 = carry); word_1 is older.
REQ-015 Port out_valid_1, out_valid_2  output  1 each  word qualifiers; out_valid_2 implies out_valid_1.
REQ-016 Port flush_done  output  1  one-cycle pulse after last flush word.

Function
REQ-017 State: low (LOW_WIDTH bits), cnt (signed, 7 bits), FSM {RUN, FLUSH, DONE}.
REQ-018 in_ready SHALL be 1 only in RUN.
REQ-019 CDF transfer (bool_1=0): if COMP_mux_1=1, low += initial_range_1 - u[RANGE_WIDTH-1:0]; then normalize with d_1.
REQ-020 Bool transfer (bool_1=1): if symbol_1, low += pre_low_1; normalize with d_1; then if bool_2, if symbol_2, low += pre_low_2; normalize with d_2. All of this completes within one cycle.
REQ-021 Normalize(d): s=cnt+d; if s>=0: c=cnt+16; if s>=8, emit low>>c, low &= 2^c-1, c-=8; emit low>>c, low &= 2^c-1, s=c+d-24; then low <<= d, cnt=s.
REQ-022 At most 2 words are emitted per transfer, in emission order on word_1 then word_2.
REQ-023 All outputs SHALL be registered, with 1-cycle latency from transfer.
REQ-024 Arithmetic SHALL truncate to LOW_WIDTH bits.
REQ-025 Emitted words SHALL keep the 9-bit carry unresolved; carry resolution is downstream.
REQ-026 On flush in RUN with no transfer, compute e = ((low+0x3FFF) & ~0x3FFF) | 0x4000, fl_c = cnt, fl_s = cnt+10, then enter FLUSH.
REQ-027 In FLUSH, while fl_s>0, each cycle emit one word e>>(fl_c+16) on word_1, set e &= 2^(fl_c+16)-1, fl_c -= 8, fl_s -= 8.
REQ-028 When fl_s<=0 in FLUSH, pulse flush_done for 1 cycle and enter DONE; if fl_s<=0 at entry, flush_done occurs 1 cycle after flush.
REQ-029 DONE SHALL hold all valids low and return to RUN on the next reset only.
REQ-030 If flush and in_valid are both high in RUN, the transfer wins and flush is ignored that cycle.
REQ-031 in_valid is ignored outside RUN: no state change.

Reset
REQ-032 Reset SHALL set low=0, cnt=-9, FSM=RUN, all out_valid and flush_done to 0, and all out_word to 0.
REQ-033 Reset asserted mid-FLUSH SHALL abort the flush with no further words and no flush_done.

Structure
REQ-034 Constants (cnt init -9, flush mask 0x3FFF, top bit 0x4000, widths) SHALL reside in the shared encoder parameter include.
REQ-035 One sub-module, s3_low_norm, SHALL implement add-then-normalize for one symbol and be instantiated twice, chained for the two-bool path.

Verification
REQ-036 Reset -> low=0, cnt=-9, no valids, in_ready=1.
REQ-037 Bool transfer (bool_1=1, bool_2=0, symbol_1=0, d_1=1) from reset -> low=0, cnt=-8, no word.
REQ-038 CDF transfer from reset (COMP_mux_1=1, initial_range_1=32768, u=20000, d_1=15) -> out_word_1=99 only; low=96<<15=3145728; cnt=-2.
REQ-039 Flush from reset state -> one word 128 on word_1, then flush_done the following cycle, then DONE with in_ready=0.
REQ-040 flush and in_valid high in the same cycle -> transfer processed, FSM stays RUN; in_valid during FLUSH -> ignored.
REQ-041 Reset asserted in the first FLUSH cycle -> no word, no flush_done, cnt=-9 next cycle.
